gamma_seq_ctrl: RTL and testbench

- Gamma-cycle sequencer and command controller for mem_group.
- Owns the aclk-domain gamma counter and generates grst, replacing the free-running counter used in benches.
- Accepts CAPTURE / REPLAY / CLEAR / NOP commands over a valid/ready interface and executes each for N whole gamma cycles, always aligned to gamma boundaries.
- Drives mem_group's grst, rst (mem_rst) and the capture/replay qualifiers.

---
 rtl/gamma_seq_ctrl_pkg.sv | 22 ++
 rtl/gamma_seq_ctrl_if.sv | 27 ++
 rtl/gamma_seq_ctrl_counter.sv | 34 +++
 rtl/gamma_seq_ctrl.sv | 116 +++++++++++
 tb/tb_gamma_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gamma_seq_ctrl_pkg.sv
// Shared types for the gamma-cycle sequencer and its command bus.
// Opcode and state encodings plus a phase-width helper.
package tnn_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_CAPTURE = 2'd1,
        OP_REPLAY  = 2'd2,
        OP_CLEAR   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ACTIVE = 2'd2
    } state_e;

    function automatic int phase_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/gamma_seq_ctrl_if.sv
// Command handshake bus between a host and the gamma sequencer.
// The host drives op/count under valid; the sequencer answers with ready.
interface gamma_seq_ctrl_if #(
    parameter int CNT_W = 8
);
    import tnn_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        output cmd_ready
    );

endinterface

// File: rtl/gamma_seq_ctrl_counter.sv
// Free-running gamma phase counter with boundary decodes.
// Reusable by any column controller that needs gamma alignment.
module gamma_counter
    import tnn_ctrl_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    localparam int PW = phase_w(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          rst,
    output logic [PW-1:0] phase,
    output logic          grst,
    output logic          last
);

    localparam logic [PW-1:0] LAST = PW'(GAMMA_CYCLE_WIDTH - 1);

    logic [PW-1:0] phase_q;

    always_ff @(posedge aclk) begin
        if (rst) begin
            phase_q <= '0;
        end else if (phase_q == LAST) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + PW'(1);
        end
    end

    assign phase = rst ? '0 : phase_q;
    assign grst  = !rst && (phase_q == '0);
    assign last  = !rst && (phase_q == LAST);

endmodule

// File: rtl/gamma_seq_ctrl.sv
// Gamma-aligned command sequencer for mem_group: runs CAPTURE/REPLAY/
// CLEAR/NOP for whole gamma cycles and drives grst, mem_rst and enables.
module gamma_seq_ctrl
    import tnn_ctrl_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int PULSE_WIDTH       = 8,
    parameter  int CNT_W             = 8,
    localparam int PW = phase_w(GAMMA_CYCLE_WIDTH)
) (
    input  logic             aclk,
    input  logic             rst,
    gamma_seq_ctrl_if.slave  cmd,
    input  logic             abort,
    output logic [PW-1:0]    phase,
    output logic             grst,
    output logic             mem_rst,
    output logic             capture_en,
    output logic             replay_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] gamma_idx
);

    localparam logic [1:0] IDLE    = S_IDLE;
    localparam logic [1:0] ARMED   = S_ARMED;
    localparam logic [1:0] ACTIVE  = S_ACTIVE;
    localparam int         CAP_END = GAMMA_CYCLE_WIDTH - PULSE_WIDTH;

    logic [1:0]       state;
    op_e              op;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] gidx;
    logic [CNT_W-1:0] cnt_in;
    logic             done_q;
    logic             abort_q;
    logic             last;
    logic             accept;
    logic             active;
    logic             run;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
    ) u_gamma (
        .aclk  (aclk),
        .rst   (rst),
        .phase (phase),
        .grst  (grst),
        .last  (last)
    );

    assign run           = !rst;
    assign cmd.cmd_ready = run && (state == IDLE);
    assign accept        = cmd.cmd_ready && cmd.cmd_valid;
    assign cnt_in        = (cmd.cmd_count == '0) ? CNT_W'(1) : cmd.cmd_count;

    always_ff @(posedge aclk) begin
        if (rst) begin
            state   <= IDLE;
            op      <= OP_NOP;
            rem     <= '0;
            gidx    <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (1'b1)
                (state == IDLE): begin
                    if (accept) begin
                        op    <= cmd.cmd_op;
                        rem   <= cnt_in;
                        gidx  <= '0;
                        state <= last ? ACTIVE : ARMED;
                    end
                end
                (state == ARMED): begin
                    if (abort) begin
                        state   <= IDLE;
                        abort_q <= 1'b1;
                    end else if (last) begin
                        state <= ACTIVE;
                    end
                end
                (state == ACTIVE): begin
                    // abort wins over a coincident final boundary: no done
                    if (abort) begin
                        state   <= IDLE;
                        abort_q <= 1'b1;
                    end else if (last) begin
                        if (gidx != '1) begin
                            gidx <= gidx + CNT_W'(1);
                        end
                        if (rem == CNT_W'(1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            rem <= rem - CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active     = run && (state == ACTIVE);
    assign busy       = run && (state != IDLE);
    assign done       = run && done_q;
    assign gamma_idx  = run ? gidx : '0;
    assign capture_en = active && (op == OP_CAPTURE) && (32'(phase) < CAP_END);
    assign replay_en  = active && (op == OP_REPLAY);
    assign mem_rst    = run && (abort_q ||
                        (active && (op == OP_CLEAR) && (phase == '0)));

endmodule

// File: tb/tb_gamma_seq_ctrl.sv
// Randomised bench for gamma_seq_ctrl: time-based reference model
// plus a done/gamma_idx scoreboard checked by an independent monitor.
module tb_gamma_seq_ctrl;
    import tnn_ctrl_pkg::*;

    localparam int G = 16;
    localparam int P = 8;
    localparam int W = 8;

    logic         aclk = 1'b0;
    logic         rst = 1'b1;
    logic         abort = 1'b0;
    logic [3:0]   phase;
    logic         grst, mem_rst, capture_en, replay_en, busy, done;
    logic [W-1:0] gamma_idx;

    always #5 aclk = ~aclk;

    gamma_seq_ctrl_if #(.CNT_W(W)) bus ();

    gamma_seq_ctrl #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(P),
        .CNT_W(W)
    ) dut (
        .aclk       (aclk),
        .rst        (rst),
        .cmd        (bus),
        .abort      (abort),
        .phase      (phase),
        .grst       (grst),
        .mem_rst    (mem_rst),
        .capture_en (capture_en),
        .replay_en  (replay_en),
        .busy       (busy),
        .done       (done),
        .gamma_idx  (gamma_idx)
    );

    // Model: one command record in absolute cycle time since reset release
    int t = 0;
    bit rv = 0;
    int rop = 0, rn = 1, rta = 0, rtab = -1;

    typedef struct {
        int tm;
        int g;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;

    function automatic int m_start();
        return (rta / G + 1) * G;
    endfunction

    function automatic int m_stop();
        return (rtab >= 0) ? rtab + 1 : m_start() + rn * G;
    endfunction

    function automatic bit m_busy(input int c);
        return rv && c > rta && c < m_stop();
    endfunction

    function automatic bit m_act(input int c);
        return rv && c >= m_start() && c < m_stop();
    endfunction

    function automatic int m_gidx(input int c);
        int g;
        int l;
        g = 0;
        if (!rv) return 0;
        for (int k = 1; k <= rn; k++) begin
            l = m_start() + k * G - 1;
            if (l < c && (rtab < 0 || l < rtab)) g++;
        end
        return g;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, got, exp);
    endtask

    // Monitor
    int ph;
    bit e_act, e_busy, e_mr, e_cap, e_rep, e_done;

    always @(negedge aclk) begin
        if (rst) begin
            chk("reset_outs", {phase, grst, mem_rst, capture_en, replay_en,
                busy, done, bus.cmd_ready, gamma_idx}, 32'd0);
        end else begin
            ph     = t % G;
            e_act  = m_act(t);
            e_busy = m_busy(t);
            e_mr   = (e_act && rop == 3 && ph == 0) ||
                     (rv && rtab >= 0 && t == rtab + 1);
            e_cap  = e_act && rop == 1 && ph < G - P;
            e_rep  = e_act && rop == 2;
            chk("phase", 32'(phase), ph);
            chk("ctrl", {grst, mem_rst, capture_en, replay_en, busy,
                bus.cmd_ready}, {ph == 0, e_mr, e_cap, e_rep, e_busy, !e_busy});
            chk("gamma_idx", 32'(gamma_idx), m_gidx(t));
            e_done = sb.size() > 0 && sb[0].tm == t;
            chk("done", 32'(done), 32'(e_done));
            if (e_done) begin
                if (done) chk("done_gidx", 32'(gamma_idx), sb[0].g);
                void'(sb.pop_front());
            end
        end
    end

    // Driver
    task automatic tick();
        bit acc, abt;
        @(posedge aclk);
        #1;
        if (rst) begin
            t = 0;
        end else begin
            acc = bus.cmd_valid && !m_busy(t);
            abt = abort && m_busy(t);
            if (abt) begin
                rtab = t;
                if (sb.size() > 0) sb.delete(sb.size() - 1);
            end
            if (acc) begin
                rv   = 1;
                rop  = int'(bus.cmd_op);
                rn   = (bus.cmd_count == 0) ? 1 : int'(bus.cmd_count);
                rta  = t;
                rtab = -1;
                sb.push_back('{m_start() + rn * G, rn});
            end
            t++;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        abort = 1'b0;
        rv = 0;
        sb.delete();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input int op, input int n);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op_e'(op);
        bus.cmd_count = W'(n);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < G && (t % G) != p; i++) tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && m_busy(t); i++) tick();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = OP_NOP;
        bus.cmd_count = '0;
        do_reset(3);
        idle(40);
        wait_phase(5);
        issue(1, 2);
        wait_idle();
        idle(3);
        wait_phase(15);
        issue(2, 1);
        wait_idle();
        idle(2);
        wait_phase(7);
        issue(3, 3);
        wait_idle();
        idle(2);
        wait_phase(2);
        issue(2, 4);
        for (int i = 0; i < 200 && t < m_start() + G + 9; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle(20);
        wait_phase(3);
        issue(1, 2);
        idle(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle(20);
        wait_phase(6);
        issue(2, 0);
        wait_idle();
        idle(2);
        wait_phase(4);
        issue(1, 1);
        wait_idle();
        issue(3, 1);
        wait_idle();
        idle(2);
        abort = 1'b1;
        issue(2, 2);
        abort = 1'b0;
        wait_idle();
        idle(2);
        wait_phase(1);
        issue(1, 3);
        idle(G + 5);
        do_reset(2);
        idle(G + 3);
        for (int i = 0; i < 2000; i++) begin
            bus.cmd_valid = ($urandom_range(0, 9) < 3);
            bus.cmd_op = op_e'($urandom_range(0, 3));
            bus.cmd_count = W'($urandom_range(0, 3));
            abort = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 499) == 0) do_reset(2);
            else tick();
        end
        bus.cmd_valid = 1'b0;
        abort = 1'b0;
        wait_idle();
        idle(G + 2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
